// File: rtl/ea_calc_pkg.sv
// Shared types, FSM encodings and instruction-field extractors for the
// effective-address calculator. Bit numbering is [0:35] with bit 0 as MSB.
package ea_calc_pkg;

  typedef logic [0:35]  word_t;
  typedef logic [18:35] addr_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_IND  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic inst_i(input word_t w);
    return w[13];
  endfunction

  function automatic logic [3:0] inst_x(input word_t w);
    return w[14:17];
  endfunction

  function automatic addr_t inst_y(input word_t w);
    return w[18:35];
  endfunction

  function automatic logic [0:12] inst_hdr(input word_t w);
    return w[0:12];
  endfunction

endpackage

// File: rtl/ea_calc.sv
// Effective-address calculator: follows index and indirect chains and hands
// the decoder a rewritten instruction with Y replaced by E.
module ea_calc
  import ea_calc_pkg::*;
#(
  parameter int INDIRECT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  word_t      inst,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output addr_t      ea,
  output word_t      inst_out,
  output logic       fault,
  output logic       fault_loop,
  output logic [3:0] ac_addr,
  input  word_t      ac_data,
  output addr_t      mem_addr,
  output logic       mem_read,
  input  logic       mem_ack,
  input  word_t      mem_data,
  input  logic       mem_fault
);

  localparam int LW = (INDIRECT_LIMIT > 0) ? $clog2(INDIRECT_LIMIT + 1) : 1;
  localparam logic [LW-1:0] LIMIT = LW'(INDIRECT_LIMIT);

  logic [1:0]    state;
  logic [0:12]   hdr;
  logic          ind_q;
  logic [3:0]    x_q;
  addr_t         y_q;
  logic [LW-1:0] level;
  logic          abort_q;

  addr_t idx;
  addr_t sum;

  // AC0 never indexes; only the right half of the index register counts.
  assign ac_addr = x_q;
  assign idx     = (x_q != 4'd0) ? ac_data[18:35] : '0;
  assign sum     = y_q + idx;

  // An abort arriving in the DONE cycle suppresses the pulse.
  assign done = (state == S_DONE) && !abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      fault      <= 1'b0;
      fault_loop <= 1'b0;
      ea         <= '0;
      inst_out   <= '0;
      mem_addr   <= '0;
      mem_read   <= 1'b0;
      hdr        <= '0;
      ind_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      level      <= '0;
      abort_q    <= 1'b0;
    end else begin
      fault      <= 1'b0;
      fault_loop <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy is still high in a fault cycle, so a start there is ignored.
          if (!busy && start && !abort) begin
            hdr     <= inst_hdr(inst);
            ind_q   <= inst_i(inst);
            x_q     <= inst_x(inst);
            y_q     <= inst_y(inst);
            level   <= '0;
            abort_q <= 1'b0;
            busy    <= 1'b1;
            state   <= S_EVAL;
          end else begin
            busy <= 1'b0;
          end
        end
        S_EVAL: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (!ind_q) begin
            ea       <= sum;
            inst_out <= {hdr, 5'b0, sum};
            state    <= S_DONE;
          end else if (INDIRECT_LIMIT != 0 && level == LIMIT) begin
            fault      <= 1'b1;
            fault_loop <= 1'b1;
            state      <= S_IDLE;
          end else begin
            mem_addr <= sum;
            mem_read <= 1'b1;
            level    <= level + 1'b1;
            state    <= S_IND;
          end
        end
        S_IND: begin
          // The bus cycle always completes; an abort only takes effect at the ack.
          if (abort) abort_q <= 1'b1;
          if (mem_ack) begin
            mem_read <= 1'b0;
            if (abort || abort_q) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else if (mem_fault) begin
              fault <= 1'b1;
              state <= S_IDLE;
            end else begin
              ind_q <= inst_i(mem_data);
              x_q   <= inst_x(mem_data);
              y_q   <= inst_y(mem_data);
              state <= S_EVAL;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ea_calc.sv
// Bench for ea_calc: table of instructions with expected EA/latency/read
// counts through a scoreboard, plus hand sequences for abort and reset.
module tb_ea_calc;
  import ea_calc_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic       busy, done, fault, fault_loop, mem_read;
  logic       mem_ack, mem_fault;
  word_t      inst, inst_out, ac_data, mem_data;
  addr_t      ea, mem_addr;
  logic [3:0] ac_addr;

  always #5 clk = ~clk;

  ea_calc #(.INDIRECT_LIMIT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .inst(inst), .abort(abort),
    .busy(busy), .done(done), .ea(ea), .inst_out(inst_out),
    .fault(fault), .fault_loop(fault_loop),
    .ac_addr(ac_addr), .ac_data(ac_data),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_ack(mem_ack),
    .mem_data(mem_data), .mem_fault(mem_fault)
  );

  word_t acs [16];
  word_t mem [int];
  assign ac_data = acs[ac_addr];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ack_wait = 0;
  int    wait_cnt = 0;
  addr_t fault_addr = 18'o600;
  addr_t reads [$];

  typedef struct {
    word_t inst;
    addr_t ea;
    bit    flt;
    bit    loop;
    int    lat;
    int    nrd;
    int    t0;
  } exp_t;

  exp_t sb [$];
  exp_t got;
  exp_t vt [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0o required=%0o", name, act, req);
    end
  endtask

  // Memory responder: ack after ack_wait extra cycles of mem_read.
  always @(negedge clk) begin
    if (reset) begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_read) begin
      if (wait_cnt >= ack_wait) begin
        mem_ack   = 1'b1;
        mem_data  = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : '0;
        mem_fault = (mem_addr == fault_addr);
        reads.push_back(mem_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset && (done || fault)) begin
      chk("done_and_fault", {63'd0, done & fault}, 64'd0);
      chk("busy_at_end", {63'd0, busy}, 64'd1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_end done=%0d fault=%0d", done, fault);
      end else begin
        got = sb.pop_front();
        chk("fault", {63'd0, fault}, {63'd0, got.flt});
        chk("fault_loop", {63'd0, fault_loop}, {63'd0, got.loop});
        chk("latency", 64'(cyc - got.t0), 64'(got.lat));
        chk("reads", 64'(reads.size()), 64'(got.nrd));
        if (!got.flt) begin
          chk("ea", {46'd0, ea}, {46'd0, got.ea});
          chk("inst_out", {28'd0, inst_out}, {28'd0, got.inst[0:12], 5'b0, got.ea});
        end
      end
    end
  end

  task automatic issue(input word_t w, input bit push, input exp_t e);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    reads.delete();
    wait_cnt = 0;
    inst = w;
    start = 1'b1;
    if (push) begin
      e.t0 = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_read();
    int n;
    n = 0;
    while (!mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mem_read_seen", {63'd0, mem_read}, 64'd1);
  endtask

  initial begin
    exp_t none;
    int   hi, n;
    none = '{inst: '0, ea: '0, flt: 0, loop: 0, lat: 0, nrd: 0, t0: 0};
    reset = 1'b1; start = 1'b0; abort = 1'b0; inst = '0;
    mem_ack = 1'b0; mem_data = '0; mem_fault = 1'b0;

    foreach (acs[i]) acs[i] = '0;
    acs[0] = 36'o123456654321;
    acs[2] = 36'o000000000007;
    acs[3] = 36'o000005000001;
    mem['o100] = 36'o000020000200;
    mem['o200] = 36'o000000000300;
    mem['o400] = 36'o000002000010;
    mem['o500] = 36'o000020000500;
    mem['o107] = 36'o000000000042;

    //         inst                ea        flt loop lat nrd
    vt[0] = '{36'o200040001234, 18'o1234, 0, 0, 2, 0, 0};
    vt[1] = '{36'o200043777777, 18'o0,    0, 0, 2, 0, 0};
    vt[2] = '{36'o200060000100, 18'o300,  0, 0, 6, 2, 0};
    vt[3] = '{36'o200060000400, 18'o17,   0, 0, 4, 1, 0};
    vt[4] = '{36'o200060000600, 18'o0,    1, 0, 3, 1, 0};
    vt[5] = '{36'o200060000500, 18'o0,    1, 1, 6, 2, 0};
    vt[6] = '{36'o200042000005, 18'o14,   0, 0, 2, 0, 0};
    vt[7] = '{36'o200062000100, 18'o42,   0, 0, 4, 1, 0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_fault", {62'd0, fault, fault_loop}, 64'd0);
    chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
    chk("rst_ea", {46'd0, ea}, 64'd0);
    chk("rst_inst_out", {28'd0, inst_out}, 64'd0);
    chk("rst_addrs", {42'd0, mem_addr, ac_addr}, 64'd0);

    foreach (vt[i]) begin
      issue(vt[i].inst, 1'b1, vt[i]);
      drain();
    end

    // abort together with start in IDLE: start ignored
    @(negedge clk);
    inst = vt[0].inst; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {63'd0, busy}, 64'd0);

    // start held through a fault cycle: only one calculation runs
    @(negedge clk);
    reads.delete();
    inst = vt[4].inst; start = 1'b1;
    got = vt[4]; got.t0 = cyc; sb.push_back(got);
    n = 0;
    while (!fault && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    start = 1'b0;
    chk("fault_start_ignored", {63'd0, busy}, 64'd0);
    drain();

    // abort during IND: bus read completes, then quietly back to IDLE
    ack_wait = 4;
    issue(36'o200060000100, 1'b0, none);
    wait_read();
    abort = 1'b1;
    hi = 0; n = 0;
    while (mem_read && n < 20) begin
      hi++;
      @(negedge clk);
      abort = 1'b0;
      n++;
    end
    chk("abort_read_hold", 64'(hi), 64'd5);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    ack_wait = 0;
    issue(vt[6].inst, 1'b1, vt[6]);
    drain();

    // reset mid-chain
    ack_wait = 4;
    issue(36'o200060000100, 1'b0, none);
    wait_read();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_mem_read", {63'd0, mem_read}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_mem_addr", {46'd0, mem_addr}, 64'd0);
    chk("midrst_ea", {46'd0, ea}, 64'd0);
    chk("midrst_inst_out", {28'd0, inst_out}, 64'd0);
    ack_wait = 0;
    issue(vt[3].inst, 1'b1, vt[3]);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
